// File: rtl/alu_unit_pkg.sv
// Shared definitions for the ALU: operation codes, flag bit positions,
// multiplier sequencer states and the single-cycle result payload.
package alu_unit_pkg;

   localparam int unsigned DATA_W  = 8;
   localparam int unsigned PROD_W  = 16;
   localparam int unsigned COUNT_W = 3;
   localparam int unsigned FLAGS_W = 4;

   localparam int unsigned FLAG_C = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_N = 1;
   localparam int unsigned FLAG_V = 0;

   localparam logic [COUNT_W-1:0] MUL_LAST = COUNT_W'(7);

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_ADC = 4'd1,
      OP_SUB = 4'd2,
      OP_SBC = 4'd3,
      OP_AND = 4'd4,
      OP_OR  = 4'd5,
      OP_XOR = 4'd6,
      OP_NOT = 4'd7,
      OP_SHL = 4'd8,
      OP_SHR = 4'd9,
      OP_ROL = 4'd10,
      OP_ROR = 4'd11,
      OP_INC = 4'd12,
      OP_DEC = 4'd13,
      OP_MUL = 4'd14,
      OP_CMP = 4'd15
   } op_e;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_MUL_RUN = 1'b1
   } mul_state_e;

   // Field order places C at bit 3 and V at bit 0 of the packed value.
   typedef struct packed {
      logic c;
      logic z;
      logic n;
      logic v;
   } flags_t;

   typedef struct packed {
      logic [DATA_W-1:0] value;
      flags_t            flags;
      logic              write_result;
   } alu_out_t;

   // 9-bit add so the carry out lands in bit 8.
   function automatic logic [DATA_W:0] add9(input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b,
                                            input logic              cin);
      return (DATA_W+1)'(a) + (DATA_W+1)'(b) + (DATA_W+1)'(cin);
   endfunction

endpackage

// File: rtl/alu_unit_mul8.sv
// Iterative 8x8 unsigned shift-and-add multiplier; one partial product per
// clock, with the final product presented combinationally on the last edge.
module alu_mul8
   import alu_unit_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              busy,
   output logic              done_c,
   output logic [PROD_W-1:0] product_c
);

   mul_state_e         state;
   logic [COUNT_W-1:0] count;
   logic [PROD_W-1:0]  mcand;
   logic [DATA_W-1:0]  mplier;
   logic [PROD_W-1:0]  acc;
   logic [PROD_W-1:0]  acc_next;

   assign acc_next  = acc + (mplier[0] ? mcand : PROD_W'(0));
   assign done_c    = (state == ST_MUL_RUN) && (count == MUL_LAST);
   assign product_c = acc_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         count  <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         busy   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state  <= ST_MUL_RUN;
                  busy   <= 1'b1;
                  count  <= '0;
                  mcand  <= PROD_W'(a);
                  mplier <= b;
                  acc    <= '0;
               end
            end
            ST_MUL_RUN: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               count  <= count + COUNT_W'(1);
               if (count == MUL_LAST) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/alu_unit.sv
// 8-bit ALU: single-cycle op decode, result/hi/flags registers, iterative
// multiply and tri-state drive of the result onto the shared data bus.
module alu_unit
   import alu_unit_pkg::*;
(
   input  logic               CLK,
   input  logic               RESET,
   input  logic [DATA_W-1:0]  LHS_in,
   input  logic [DATA_W-1:0]  RHS_in,
   input  logic [3:0]         OP,
   input  logic               START_bar,
   input  logic               ASSERT_bar,
   input  logic               ASSERT_HI_bar,
   output logic [DATA_W-1:0]  BUS_out,
   output logic [FLAGS_W-1:0] FLAGS,
   output logic               BUSY,
   output logic [DATA_W-1:0]  display_value
);

   op_e               op;
   logic [DATA_W-1:0] result_q;
   logic [DATA_W-1:0] hi_q;
   flags_t            flags_q;

   logic              mul_busy;
   logic              mul_done_c;
   logic [PROD_W-1:0] product_c;
   logic              accept_c;
   logic              mul_start_c;

   logic [DATA_W-1:0] rhs_eff;
   logic              cin;
   logic [DATA_W:0]   sum9;
   logic              ovf;
   logic [DATA_W-1:0] y;
   alu_out_t          alu_c;
   flags_t            mul_flags_c;

   assign op          = op_e'(OP);
   // A start strobe while the multiplier runs is dropped entirely.
   assign accept_c    = !START_bar && !mul_busy;
   assign mul_start_c = accept_c && (op == OP_MUL);

   alu_mul8 u_mul (
      .clk       (CLK),
      .reset     (RESET),
      .start     (mul_start_c),
      .a         (LHS_in),
      .b         (RHS_in),
      .busy      (mul_busy),
      .done_c    (mul_done_c),
      .product_c (product_c)
   );

   // Adder operand select: subtracts are LHS + ~RHS + cin, INC/DEC add +1/-1.
   always_comb begin
      rhs_eff = RHS_in;
      cin     = 1'b0;
      case (op)
         OP_ADC:         cin = flags_q.c;
         OP_SUB, OP_CMP: begin rhs_eff = ~RHS_in; cin = 1'b1;      end
         OP_SBC:         begin rhs_eff = ~RHS_in; cin = flags_q.c; end
         OP_INC:         rhs_eff = DATA_W'(1);
         OP_DEC:         rhs_eff = {DATA_W{1'b1}};
         default:        ;
      endcase
      sum9 = add9(LHS_in, rhs_eff, cin);
      ovf  = (LHS_in[DATA_W-1] == rhs_eff[DATA_W-1]) &&
             (sum9[DATA_W-1] != LHS_in[DATA_W-1]);
   end

   always_comb begin
      y                  = sum9[DATA_W-1:0];
      alu_c.flags.c      = flags_q.c;
      alu_c.flags.v      = 1'b0;
      alu_c.write_result = 1'b1;
      case (op)
         OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
            alu_c.flags.c = sum9[DATA_W];
            alu_c.flags.v = ovf;
         end
         OP_CMP: begin
            alu_c.flags.c      = sum9[DATA_W];
            alu_c.flags.v      = ovf;
            alu_c.write_result = 1'b0;
         end
         OP_INC, OP_DEC: alu_c.flags.v = ovf;
         OP_AND: y = LHS_in & RHS_in;
         OP_OR:  y = LHS_in | RHS_in;
         OP_XOR: y = LHS_in ^ RHS_in;
         OP_NOT: y = ~LHS_in;
         OP_SHL: begin
            y             = {LHS_in[DATA_W-2:0], 1'b0};
            alu_c.flags.c = LHS_in[DATA_W-1];
         end
         OP_SHR: begin
            y             = {1'b0, LHS_in[DATA_W-1:1]};
            alu_c.flags.c = LHS_in[0];
         end
         OP_ROL: begin
            y             = {LHS_in[DATA_W-2:0], flags_q.c};
            alu_c.flags.c = LHS_in[DATA_W-1];
         end
         OP_ROR: begin
            y             = {flags_q.c, LHS_in[DATA_W-1:1]};
            alu_c.flags.c = LHS_in[0];
         end
         OP_MUL: alu_c.write_result = 1'b0;
         default: ;
      endcase
      alu_c.value   = y;
      alu_c.flags.z = (y == '0);
      alu_c.flags.n = y[DATA_W-1];
   end

   always_comb begin
      mul_flags_c.c = |product_c[PROD_W-1:DATA_W];
      mul_flags_c.z = (product_c == '0);
      mul_flags_c.n = product_c[PROD_W-1];
      mul_flags_c.v = 1'b0;
   end

   // Multiply completion and single-cycle ops never coincide: BUSY blocks starts.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         result_q <= '0;
         hi_q     <= '0;
         flags_q  <= '0;
      end else if (mul_done_c) begin
         result_q <= product_c[DATA_W-1:0];
         hi_q     <= product_c[PROD_W-1:DATA_W];
         flags_q  <= mul_flags_c;
      end else if (accept_c && (op != OP_MUL)) begin
         flags_q <= alu_c.flags;
         if (alu_c.write_result) begin
            result_q <= alu_c.value;
         end
      end
   end

   assign BUS_out = !ASSERT_bar    ? result_q :
                    !ASSERT_HI_bar ? hi_q     : {DATA_W{1'bz}};

   assign FLAGS         = flags_q;
   assign BUSY          = mul_busy;
   assign display_value = result_q;

endmodule

// File: tb/tb_alu_unit.sv
// Bench for alu_unit: directed scenarios plus randomized ops checked against
// an arithmetic reference model. The bus has pull-ups so an undriven bus reads 0xFF.
module tb_alu_unit;

   localparam logic [3:0] ADD = 4'd0,  ADC = 4'd1,  SUB = 4'd2,  SBC = 4'd3;
   localparam logic [3:0] AND_ = 4'd4, OR_ = 4'd5,  XOR_ = 4'd6, NOT_ = 4'd7;
   localparam logic [3:0] SHL = 4'd8,  SHR = 4'd9,  ROL = 4'd10, ROR = 4'd11;
   localparam logic [3:0] INC = 4'd12, DEC = 4'd13, MUL = 4'd14, CMP = 4'd15;

   logic       clk;
   logic       reset;
   logic [7:0] lhs;
   logic [7:0] rhs;
   logic [3:0] op;
   logic       start_bar;
   logic       assert_bar;
   logic       assert_hi_bar;
   wire  [7:0] bus;
   logic [3:0] flags;
   logic       busy;
   logic [7:0] disp;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [7:0] m_res, m_hi;
   logic       m_c, m_z, m_n, m_v;

   for (genvar g = 0; g < 8; g++) begin : g_pu
      pullup (bus[g]);
   end

   alu_unit dut (
      .CLK           (clk),
      .RESET         (reset),
      .LHS_in        (lhs),
      .RHS_in        (rhs),
      .OP            (op),
      .START_bar     (start_bar),
      .ASSERT_bar    (assert_bar),
      .ASSERT_HI_bar (assert_hi_bar),
      .BUS_out       (bus),
      .FLAGS         (flags),
      .BUSY          (busy),
      .display_value (disp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running want finished");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [3:0] m_flags();
      return {m_c, m_z, m_n, m_v};
   endfunction

   task automatic model_reset();
      m_res = 8'h00; m_hi = 8'h00;
      m_c = 1'b0; m_z = 1'b0; m_n = 1'b0; m_v = 1'b0;
   endtask

   // Behavioural model using integer arithmetic on the operation definitions.
   task automatic model_apply(input logic [3:0] o, input logic [7:0] l, input logic [7:0] r);
      int         a, b, sa, sb, d, s, p;
      logic [7:0] yv;
      logic       wr;
      a = int'(l); b = int'(r); sa = int'($signed(l)); sb = int'($signed(r));
      wr = 1'b1; m_v = 1'b0; yv = 8'h00;
      case (o)
         ADD, ADC: begin
            d = a + b + ((o == ADC) ? int'(m_c) : 0);
            s = sa + sb + ((o == ADC) ? int'(m_c) : 0);
            yv = 8'(d); m_c = (d > 255); m_v = (s > 127) || (s < -128);
         end
         SUB, SBC, CMP: begin
            p = (o == SBC) ? (m_c ? 0 : 1) : 0;
            d = a - b - p; s = sa - sb - p;
            yv = 8'(d); m_c = (d >= 0); m_v = (s > 127) || (s < -128);
            wr = (o != CMP);
         end
         AND_: yv = l & r;
         OR_:  yv = l | r;
         XOR_: yv = l ^ r;
         NOT_: yv = 8'(255 - a);
         SHL: begin yv = 8'(a * 2); m_c = (a >= 128); end
         SHR: begin yv = 8'(a / 2); m_c = (a % 2) == 1; end
         ROL: begin yv = 8'(a * 2 + int'(m_c)); m_c = (a >= 128); end
         ROR: begin yv = 8'(a / 2 + int'(m_c) * 128); m_c = (a % 2) == 1; end
         INC: begin yv = 8'(a + 1); m_v = (sa + 1 > 127); end
         DEC: begin yv = 8'(a - 1); m_v = (sa - 1 < -128); end
         default: begin
            p = a * b;
            yv = 8'(p % 256); m_hi = 8'(p / 256);
            m_c = (p >= 256);
         end
      endcase
      if (o == MUL) begin
         m_z = (p == 0); m_n = (p >= 32768);
      end else begin
         m_z = (yv == 8'h00); m_n = yv[7];
      end
      if (wr) m_res = yv;
   endtask

   task automatic read_bus(input logic a_n, input logic h_n, output logic [7:0] v);
      assert_bar = a_n; assert_hi_bar = h_n;
      #1 v = bus;
      assert_bar = 1'b1; assert_hi_bar = 1'b1;
      #1;
   endtask

   // Issue one op, scramble operands after the start edge, wait out a multiply.
   task automatic run_op(input logic [3:0] o, input logic [7:0] l, input logic [7:0] r);
      int n;
      @(negedge clk);
      op = o; lhs = l; rhs = r; start_bar = 1'b0;
      @(negedge clk);
      start_bar = 1'b1; lhs = 8'($urandom); rhs = 8'($urandom);
      if (o == MUL) begin
         n = 0;
         while (busy && n < 20) begin
            @(negedge clk);
            n++;
         end
         total++;
         if (busy !== 1'b0) begin
            bad++;
            $display("FAIL mul_timeout: busy=%b want 0", busy);
         end
      end
      model_apply(o, l, r);
   endtask

   task automatic test_reset();
      logic [7:0] v;
      reset = 1'b1; start_bar = 1'b1; assert_bar = 1'b1; assert_hi_bar = 1'b1;
      op = ADD; lhs = 8'h00; rhs = 8'h00;
      repeat (2) @(negedge clk);
      model_reset();
      total++; if (disp !== 8'h00) begin bad++; $display("FAIL reset_result: got %h want 00", disp); end
      total++; if (flags !== 4'h0) begin bad++; $display("FAIL reset_flags: got %b want 0000", flags); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      read_bus(1'b1, 1'b1, v);
      total++; if (v !== 8'hFF) begin bad++; $display("FAIL reset_bus_hiz: got %h want FF(pulled)", v); end
      // reset wins over a simultaneous start
      op = ADD; lhs = 8'h10; rhs = 8'h20; start_bar = 1'b0;
      @(negedge clk);
      start_bar = 1'b1; reset = 1'b0;
      total++; if (disp !== 8'h00) begin bad++; $display("FAIL reset_priority: got %h want 00", disp); end
   endtask

   task automatic test_add();
      run_op(ADD, 8'h7F, 8'h01);
      total++; if (disp !== 8'h80) begin bad++; $display("FAIL add_ovf_result: got %h want 80", disp); end
      total++; if (flags !== 4'b0011) begin bad++; $display("FAIL add_ovf_flags: got %b want 0011", flags); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL add_busy: got %b want 0", busy); end
      run_op(ADD, 8'hFF, 8'h01);
      total++; if (disp !== 8'h00) begin bad++; $display("FAIL add_carry_result: got %h want 00", disp); end
      total++; if (flags !== 4'b1100) begin bad++; $display("FAIL add_carry_flags: got %b want 1100", flags); end
      run_op(ADC, 8'h00, 8'h00);
      total++; if (disp !== 8'h01) begin bad++; $display("FAIL adc_result: got %h want 01", disp); end
      total++; if (flags !== 4'b0000) begin bad++; $display("FAIL adc_flags: got %b want 0000", flags); end
   endtask

   task automatic test_cmp_sub();
      run_op(OR_, 8'hAA, 8'h00);
      run_op(CMP, 8'h05, 8'h09);
      total++; if (disp !== 8'hAA) begin bad++; $display("FAIL cmp_keeps_result: got %h want AA", disp); end
      total++; if (flags !== 4'b0010) begin bad++; $display("FAIL cmp_flags: got %b want 0010", flags); end
      run_op(SUB, 8'h10, 8'h10);
      total++; if (disp !== 8'h00) begin bad++; $display("FAIL sub_result: got %h want 00", disp); end
      total++; if (flags !== 4'b1100) begin bad++; $display("FAIL sub_flags: got %b want 1100", flags); end
   endtask

   task automatic test_rotate();
      run_op(ROR, 8'h02, 8'h00);
      total++; if (disp !== 8'h81) begin bad++; $display("FAIL ror_result: got %h want 81", disp); end
      total++; if (flags !== 4'b0010) begin bad++; $display("FAIL ror_flags: got %b want 0010", flags); end
      run_op(SHL, 8'h81, 8'h00);
      total++; if (disp !== 8'h02) begin bad++; $display("FAIL shl_result: got %h want 02", disp); end
      total++; if (flags !== 4'b1000) begin bad++; $display("FAIL shl_flags: got %b want 1000", flags); end
   endtask

   task automatic test_mul();
      int         cycles;
      logic [7:0] v;
      @(negedge clk);
      op = MUL; lhs = 8'hFF; rhs = 8'hFF; start_bar = 1'b0;
      @(negedge clk);
      start_bar = 1'b1; lhs = 8'h01; rhs = 8'h01;
      cycles = 0;
      for (int i = 0; i < 20 && busy; i++) begin
         cycles++;
         if (i == 2) begin
            read_bus(1'b0, 1'b1, v);
            total++; if (v !== 8'h02) begin bad++; $display("FAIL mul_bus_old_result: got %h want 02", v); end
         end
         // starts at i==3 (mid-run) and i==7 (edge k+8) must both be dropped
         op = ADD;
         start_bar = (i == 3 || i == 7) ? 1'b0 : 1'b1;
         @(negedge clk);
      end
      start_bar = 1'b1;
      model_apply(MUL, 8'hFF, 8'hFF);
      total++; if (cycles != 8) begin bad++; $display("FAIL mul_busy_cycles: got %0d want 8", cycles); end
      total++; if (disp !== 8'h01) begin bad++; $display("FAIL mul_lo: got %h want 01", disp); end
      total++; if (flags !== 4'b1010) begin bad++; $display("FAIL mul_flags: got %b want 1010", flags); end
      read_bus(1'b1, 1'b0, v);
      total++; if (v !== 8'hFE) begin bad++; $display("FAIL mul_hi_bus: got %h want FE", v); end
      read_bus(1'b0, 1'b0, v);
      total++; if (v !== 8'h01) begin bad++; $display("FAIL mul_both_asserts: got %h want 01", v); end
   endtask

   task automatic test_reset_mid_mul();
      logic [7:0] v;
      @(negedge clk);
      op = MUL; lhs = 8'h03; rhs = 8'h05; start_bar = 1'b0;
      @(negedge clk);
      start_bar = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mul_busy: got %b want 0", busy); end
      total++; if (disp !== 8'h00) begin bad++; $display("FAIL rst_mul_result: got %h want 00", disp); end
      total++; if (flags !== 4'h0) begin bad++; $display("FAIL rst_mul_flags: got %b want 0000", flags); end
      read_bus(1'b1, 1'b0, v);
      total++; if (v !== 8'h00) begin bad++; $display("FAIL rst_mul_hi: got %h want 00", v); end
      repeat (10) @(negedge clk);
      total++; if (disp !== 8'h00 || busy !== 1'b0) begin
         bad++; $display("FAIL rst_mul_discarded: got result=%h busy=%b want 00/0", disp, busy);
      end
      run_op(ADD, 8'h02, 8'h03);
      total++; if (disp !== 8'h05) begin bad++; $display("FAIL post_rst_add: got %h want 05", disp); end
      read_bus(1'b1, 1'b1, v);
      total++; if (v !== 8'hFF) begin bad++; $display("FAIL bus_hiz: got %h want FF(pulled)", v); end
   endtask

   task automatic test_random();
      logic [3:0] o;
      logic [7:0] l, r, v;
      for (int i = 0; i < 150; i++) begin
         o = 4'($urandom_range(0, 15));
         l = 8'($urandom);
         r = 8'($urandom);
         run_op(o, l, r);
         total++; if (disp !== m_res) begin
            bad++; $display("FAIL rand_result op=%0d l=%h r=%h: got %h want %h", o, l, r, disp, m_res);
         end
         total++; if (flags !== m_flags()) begin
            bad++; $display("FAIL rand_flags op=%0d l=%h r=%h: got %b want %b", o, l, r, flags, m_flags());
         end
         read_bus(1'b1, 1'b0, v);
         total++; if (v !== m_hi) begin
            bad++; $display("FAIL rand_hi op=%0d: got %h want %h", o, v, m_hi);
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_cmp_sub();
      test_rotate();
      test_mul();
      test_reset_mid_mul();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
